// File: rtl/axi4_lite_master_if.sv
// axi4_lite_master_if
//   Bundles every non-clock signal of axi4_lite_master: the command port,
//   the held-valid response port, the sticky error flag and the five AXI4-Lite
//   channels (AW/W/B/AR/R) toward the downstream slave.
//   modport master : the view of axi4_lite_master itself
//   modport slave  : the view of whatever drives commands and models the slave
// Parameters: ADDRESS (address width), DATA_WIDTH (data width, strobes DATA_WIDTH/8)
interface axi4_lite_master_if #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    // command / response side
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDRESS-1:0]    cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_W-1:0]     cmd_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  err_sticky;
    logic                  err_clear;

    // AXI4-Lite side
    logic [ADDRESS-1:0]    M_AWADDR;
    logic                  M_AWVALID;
    logic                  M_AWREADY;
    logic [DATA_WIDTH-1:0] M_WDATA;
    logic [STRB_W-1:0]     M_WSTRB;
    logic                  M_WVALID;
    logic                  M_WREADY;
    logic [1:0]            M_BRESP;
    logic                  M_BVALID;
    logic                  M_BREADY;
    logic [ADDRESS-1:0]    M_ARADDR;
    logic                  M_ARVALID;
    logic                  M_ARREADY;
    logic [DATA_WIDTH-1:0] M_RDATA;
    logic [1:0]            M_RRESP;
    logic                  M_RVALID;
    logic                  M_RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready, err_clear,
               M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, err_sticky,
               M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
               M_ARADDR, M_ARVALID, M_RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready, err_clear,
               M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, err_sticky,
               M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
               M_ARADDR, M_ARVALID, M_RREADY
    );
endinterface

// File: rtl/axi4_lite_master.sv
// axi4_lite_master
//   Single-outstanding AXI4-Lite master. A command accepted on the cmd port
//   becomes one AXI write (AW+W then B) or read (AR then R); the result is
//   returned on a held-valid rsp port. Every output is a register.
// Ports:
//   ACLK   : clock, rising edge
//   ARESET : asynchronous active-high reset; aborts any transaction in flight
//   bus    : axi4_lite_master_if.master (cmd/rsp/err + AW/W/B/AR/R channels)
// Build option:
//   AXI4_LITE_MASTER_ERR_STICKY_EN - when defined, err_sticky latches any
//   non-OKAY B/R response until err_clear; otherwise err_sticky is tied 0.
module axi4_lite_master #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic               ACLK,
    input logic               ARESET,
    axi4_lite_master_if.master bus
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, DONE} state_t;

    state_t                state_q;
    logic                  cmd_ready_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                  aw_done_q, w_done_q;
    logic [ADDRESS-1:0]    awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  rsp_valid_q, rsp_write_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]            rsp_resp_q;

    // READY outputs are only ever high in their own state, so a B/R arriving
    // elsewhere never completes a handshake.
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = awvalid_q && bus.M_AWREADY;
    assign w_hs  = wvalid_q  && bus.M_WREADY;
    assign b_hs  = bready_q  && bus.M_BVALID;
    assign ar_hs = arvalid_q && bus.M_ARREADY;
    assign r_hs  = rready_q  && bus.M_RVALID;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    // cmd_ready comes up one cycle after entering IDLE, which
                    // also gives the post-reset behaviour for free.
                    if (cmd_ready_q && bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_write) begin
                            awaddr_q  <= bus.cmd_addr;
                            wdata_q   <= bus.cmd_wdata;
                            wstrb_q   <= bus.cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                            state_q   <= WRITE;
                        end else begin
                            araddr_q  <= bus.cmd_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= RADDR;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    // a handshake in this very cycle counts toward completion
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= WRESP;
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= bus.M_BRESP;
                        state_q     <= DONE;
                    end
                end
                RADDR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RDATA;
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b0;
                        rsp_rdata_q <= bus.M_RDATA;
                        rsp_resp_q  <= bus.M_RRESP;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXI4_LITE_MASTER_ERR_STICKY_EN
    logic err_q, err_d, err_set;
    // set beats clear when both land in the same cycle
    always_comb begin
        err_set = (b_hs && (bus.M_BRESP != 2'b00)) || (r_hs && (bus.M_RRESP != 2'b00));
        err_d   = err_q;
        if (bus.err_clear) err_d = 1'b0;
        if (err_set)       err_d = 1'b1;
    end
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign bus.err_sticky = err_q;
`else
    assign bus.err_sticky = 1'b0;
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_resp  = rsp_resp_q;
    assign bus.M_AWADDR  = awaddr_q;
    assign bus.M_AWVALID = awvalid_q;
    assign bus.M_WDATA   = wdata_q;
    assign bus.M_WSTRB   = wstrb_q;
    assign bus.M_WVALID  = wvalid_q;
    assign bus.M_BREADY  = bready_q;
    assign bus.M_ARADDR  = araddr_q;
    assign bus.M_ARVALID = arvalid_q;
    assign bus.M_RREADY  = rready_q;
endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master
//   Drives commands into axi4_lite_master while playing the AXI4-Lite slave,
//   with randomized ready/valid delays and responses. Expected responses come
//   from a word-addressed memory model with strobe merging plus a sticky-error
//   flag model. Directed cases: zero-wait write, read-back, split AW/W,
//   response backpressure, error reporting, reset in WRESP.
module tb_axi4_lite_master;
    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    axi4_lite_master_if #(.ADDRESS(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_master #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
        .ACLK  (ACLK),
        .ARESET(ARESET),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [31:0]];
    logic        err_exp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic tb_idle();
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.rsp_ready = 0; bus.err_clear = 0;
        bus.M_AWREADY = 0; bus.M_WREADY = 0; bus.M_BRESP = 2'b00; bus.M_BVALID = 0;
        bus.M_ARREADY = 0; bus.M_RDATA = '0; bus.M_RRESP = 2'b00; bus.M_RVALID = 0;
    endtask

    task automatic chk_reset_outs(input string pre);
        chk({pre, "_cmd_ready"}, bus.cmd_ready, 0);
        chk({pre, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({pre, "_rsp_write"}, bus.rsp_write, 0);
        chk({pre, "_rsp_rdata"}, bus.rsp_rdata, 0);
        chk({pre, "_rsp_resp"},  bus.rsp_resp, 0);
        chk({pre, "_err"},       bus.err_sticky, 0);
        chk({pre, "_valids"},    {bus.M_AWVALID, bus.M_WVALID, bus.M_ARVALID}, 0);
        chk({pre, "_readies"},   {bus.M_BREADY, bus.M_RREADY}, 0);
        chk({pre, "_awaddr"},    bus.M_AWADDR, 0);
        chk({pre, "_wdata"},     bus.M_WDATA, 0);
        chk({pre, "_wstrb"},     bus.M_WSTRB, 0);
        chk({pre, "_araddr"},    bus.M_ARADDR, 0);
    endtask

    // One complete command: ad/dd = AW/W (or AR) ready delays, rd = B/R valid
    // delay, hold = cycles rsp_ready stays low before acceptance.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int ad, input int dd, input int rd,
                           input logic [1:0] resp, input int hold);
        logic [31:0] exp_rdata;
        logic [31:0] v;
        int          cyc;
        bit          a_done, d_done, ah, dh, ok;
        cyc = 0;
        while (1) begin
            @(negedge ACLK);
            if (bus.cmd_ready) break;
            cyc++;
            if (cyc > 50) begin chk("cmd_ready_timeout", 0, 1); break; end
        end
        bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr;
        bus.cmd_wdata = data; bus.cmd_wstrb = strb;
        @(posedge ACLK); #1;
        bus.cmd_valid = 0;
        if (wr) begin
            a_done = 0; d_done = 0; cyc = 0;
            while (!(a_done && d_done) && cyc < 60) begin
                bus.M_AWREADY = !a_done && (cyc >= ad);
                bus.M_WREADY  = !d_done && (cyc >= dd);
                @(negedge ACLK);
                chk("awvalid", bus.M_AWVALID, !a_done);
                if (!a_done) chk("awaddr", bus.M_AWADDR, addr);
                chk("wvalid", bus.M_WVALID, !d_done);
                if (!d_done) begin
                    chk("wdata", bus.M_WDATA, data);
                    chk("wstrb", bus.M_WSTRB, strb);
                end
                chk("bready_early", bus.M_BREADY, 0);
                ah = bus.M_AWVALID && bus.M_AWREADY;
                dh = bus.M_WVALID && bus.M_WREADY;
                @(posedge ACLK); #1;
                a_done |= ah; d_done |= dh; cyc++;
            end
            chk("w_phase_cycles", cyc, ((ad > dd) ? ad : dd) + 1);
            bus.M_AWREADY = 0; bus.M_WREADY = 0;
            v = mem_rd(addr);
            for (int b = 0; b < 4; b++)
                if (strb[b]) v[b*8 +: 8] = data[b*8 +: 8];
            mem[addr] = v;
            exp_rdata = 32'h0;
            cyc = 0; ok = 0; bus.M_BRESP = resp;
            while (!ok && cyc < 60) begin
                bus.M_BVALID = (cyc >= rd);
                @(negedge ACLK);
                chk("bready", bus.M_BREADY, 1);
                ok = bus.M_BVALID && bus.M_BREADY;
                @(posedge ACLK); #1;
                cyc++;
            end
            chk("b_phase_cycles", cyc, rd + 1);
            bus.M_BVALID = 0;
        end else begin
            cyc = 0; ok = 0;
            while (!ok && cyc < 60) begin
                bus.M_ARREADY = (cyc >= ad);
                @(negedge ACLK);
                chk("arvalid", bus.M_ARVALID, 1);
                chk("araddr", bus.M_ARADDR, addr);
                chk("rready_early", bus.M_RREADY, 0);
                ok = bus.M_ARVALID && bus.M_ARREADY;
                @(posedge ACLK); #1;
                cyc++;
            end
            chk("ar_phase_cycles", cyc, ad + 1);
            bus.M_ARREADY = 0;
            exp_rdata = mem_rd(addr);
            cyc = 0; ok = 0; bus.M_RDATA = exp_rdata; bus.M_RRESP = resp;
            while (!ok && cyc < 60) begin
                bus.M_RVALID = (cyc >= rd);
                @(negedge ACLK);
                chk("rready", bus.M_RREADY, 1);
                ok = bus.M_RVALID && bus.M_RREADY;
                @(posedge ACLK); #1;
                cyc++;
            end
            chk("r_phase_cycles", cyc, rd + 1);
            bus.M_RVALID = 0; bus.M_RDATA = 32'h0;
        end
`ifdef AXI4_LITE_MASTER_ERR_STICKY_EN
        if (resp != 2'b00) err_exp = 1'b1;
`endif
        for (int h = 0; h <= hold; h++) begin
            bus.rsp_ready = (h == hold);
            @(negedge ACLK);
            chk("rsp_valid", bus.rsp_valid, 1);
            chk("rsp_write", bus.rsp_write, wr);
            chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
            chk("rsp_resp", bus.rsp_resp, resp);
            chk("cmd_ready_busy", bus.cmd_ready, 0);
            chk("err_sticky", bus.err_sticky, err_exp);
            @(posedge ACLK); #1;
        end
        bus.rsp_ready = 0;
        @(negedge ACLK);
        chk("rsp_drop", bus.rsp_valid, 0);
        chk("cmd_ready_gap", bus.cmd_ready, 0);
        @(negedge ACLK);
        chk("cmd_ready_back", bus.cmd_ready, 1);
    endtask

    initial begin
        tb_idle();
        ARESET = 1'b0;
        #1 ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 chk_reset_outs("rst");
        @(negedge ACLK);
        ARESET = 1'b0;
        #1 chk("cmd_ready_pre_edge", bus.cmd_ready, 0);
        @(negedge ACLK);
        chk("cmd_ready_post_rst", bus.cmd_ready, 1);

        // zero-wait write then read-back
        run_txn(1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0);
        run_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0);
        // AW delayed, W immediate; and the reverse
        run_txn(1, 32'h8, 32'h12345678, 4'hF, 3, 0, 1, 2'b00, 0);
        run_txn(1, 32'hC, 32'hCAFEF00D, 4'h5, 0, 2, 0, 2'b00, 0);
        // response backpressure
        run_txn(0, 32'h8, 32'h0, 4'h0, 1, 0, 2, 2'b00, 4);
        // error read
        run_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 1, 2'b10, 1);
        repeat (3) begin
            @(negedge ACLK);
            chk("err_hold", bus.err_sticky, err_exp);
        end
        @(posedge ACLK); #1 bus.err_clear = 1;
        @(posedge ACLK); #1 bus.err_clear = 0;
        err_exp = 1'b0;
        @(negedge ACLK);
        chk("err_cleared", bus.err_sticky, 0);

        // reset while waiting in WRESP
        begin : mid_reset
            int cyc;
            cyc = 0;
            while (!bus.cmd_ready && cyc < 50) begin @(negedge ACLK); cyc++; end
            bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 32'h10;
            bus.cmd_wdata = 32'hA5A5A5A5; bus.cmd_wstrb = 4'hF;
            @(posedge ACLK); #1;
            bus.cmd_valid = 0; bus.M_AWREADY = 1; bus.M_WREADY = 1;
            @(posedge ACLK); #1;
            bus.M_AWREADY = 0; bus.M_WREADY = 0;
            @(negedge ACLK);
            chk("mid_bready", bus.M_BREADY, 1);
            #2 ARESET = 1'b1;
            #1 chk_reset_outs("midrst");
            tb_idle();
            err_exp = 1'b0;
            @(negedge ACLK);
            ARESET = 1'b0;
            @(negedge ACLK);
            chk("cmd_ready_after_midrst", bus.cmd_ready, 1);
        end
        run_txn(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            bit          wr;
            logic [31:0] a;
            logic [1:0]  rs;
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 3)) << 2;
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(wr, a, $urandom, 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), rs, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
